// File: rtl/spi_if.sv
// Host-side request/status bundle for the SPI register-write master.
// The slave modport is the SPI block's view; master is the host's view.
interface spi_if;
  logic       i_txBegin;
  logic [6:0] i_txAddress;
  logic [7:0] i_txData;
  logic       o_txBusy;
  logic       o_txDone;
  logic       o_sen;
  logic       o_sck;
  logic       o_sdat;

  modport slave (
    input  i_txBegin, i_txAddress, i_txData,
    output o_txBusy, o_txDone, o_sen, o_sck, o_sdat
  );

  modport master (
    output i_txBegin, i_txAddress, i_txData,
    input  o_txBusy, o_txDone, o_sen, o_sck, o_sdat
  );
endinterface

// File: rtl/spi.sv
// SPI write-only master: sends {0, addr[6:0], data[7:0]} MSB first.
// Frame: LEAD (sen low, sck low, one half-period), 16 bits of
// sck high/low half-periods, then a single FINISH cycle with txDone.
// Every output comes straight from a flop.
module spi #(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic i_clock,
  input  logic i_reset_n,
  spi_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, FINISH} state_t;

  localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

  state_t      state, stateNext;
  logic [7:0]  cnt, cntNext;
  logic [3:0]  bitCnt, bitCntNext;
  logic [15:0] shreg, shregNext;
  logic        sen, senNext;
  logic        sck, sckNext;
  logic        sdat, sdatNext;
  logic        busy, busyNext;
  logic        done, doneNext;
  logic        halfDone;

  assign halfDone = (cnt == HP_LAST);

  // State, counters, shift register and all outputs; reset aborts any frame.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      bitCnt <= '0;
      shreg  <= '0;
      sen    <= 1'b1;
      sck    <= 1'b0;
      sdat   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      bitCnt <= bitCntNext;
      shreg  <= shregNext;
      sen    <= senNext;
      sck    <= sckNext;
      sdat   <= sdatNext;
      busy   <= busyNext;
      done   <= doneNext;
    end
  end

  // Next-state and next-output decode; data moves only on sck falling.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    bitCntNext = bitCnt;
    shregNext  = shreg;
    senNext    = sen;
    sckNext    = sck;
    sdatNext   = sdat;
    busyNext   = busy;
    doneNext   = 1'b0;
    case (state)
      IDLE: begin
        senNext    = 1'b1;
        sckNext    = 1'b0;
        sdatNext   = 1'b0;
        busyNext   = 1'b0;
        cntNext    = '0;
        bitCntNext = '0;
        if (bus.i_txBegin) begin
          stateNext = LEAD;
          shregNext = {1'b0, bus.i_txAddress, bus.i_txData};
          sdatNext  = 1'b0;
          senNext   = 1'b0;
          busyNext  = 1'b1;
        end
      end
      LEAD: begin
        // hold the MSB for one half-period ahead of the first rising edge
        sdatNext = shreg[15];
        if (halfDone) begin
          stateNext = SHIFT;
          sckNext   = 1'b1;
          cntNext   = '0;
        end else begin
          cntNext = cnt + 8'd1;
        end
      end
      SHIFT: begin
        if (!halfDone) begin
          cntNext = cnt + 8'd1;
        end else begin
          cntNext = '0;
          if (sck) begin
            sckNext   = 1'b0;
            shregNext = {shreg[14:0], 1'b0};
            sdatNext  = shreg[14];
          end else if (bitCnt == 4'd15) begin
            stateNext = FINISH;
            senNext   = 1'b1;
            sdatNext  = 1'b0;
            busyNext  = 1'b0;
            doneNext  = 1'b1;
          end else begin
            sckNext    = 1'b1;
            bitCntNext = bitCnt + 4'd1;
          end
        end
      end
      FINISH: begin
        // start requests seen here are dropped; IDLE takes the next one
        stateNext = IDLE;
        shregNext = '0;
      end
      default: stateNext = IDLE;
    endcase
  end

  assign bus.o_sen    = sen;
  assign bus.o_sck    = sck;
  assign bus.o_sdat   = sdat;
  assign bus.o_txBusy = busy;
  assign bus.o_txDone = done;

endmodule

// File: tb/tb_spi.sv
// Bench for spi: dutA at HALF_PERIOD=2, dutB at HALF_PERIOD=1.
// A negedge monitor decodes what a slave would sample; tasks compare
// against frames and durations computed from the frame rules.
module tb_spi;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nVec = 0;
  int   nMis = 0;

  always #5 clk = ~clk;

  spi_if busA();
  spi_if busB();

  spi #(.HALF_PERIOD(2)) dutA (.i_clock(clk), .i_reset_n(rst_n), .bus(busA.slave));
  spi #(.HALF_PERIOD(1)) dutB (.i_clock(clk), .i_reset_n(rst_n), .bus(busB.slave));

  logic [1:0] sck, sdat, sen, busy, done;
  assign sck  = {busB.o_sck,    busA.o_sck};
  assign sdat = {busB.o_sdat,   busA.o_sdat};
  assign sen  = {busB.o_sen,    busA.o_sen};
  assign busy = {busB.o_txBusy, busA.o_txBusy};
  assign done = {busB.o_txDone, busA.o_txDone};

  int hp[2] = '{2, 1};

  // monitor state per DUT
  int          rises[2], senLow[2], busyCyc[2], noTog[2];
  int          lastRises[2], lastSenLow[2], lastBusy[2], lastNoTog[2];
  int          doneCnt[2] = '{0, 0};
  int          glitch[2] = '{0, 0};
  int          senHighRise[2] = '{0, 0};
  logic [15:0] cap[2], lastCap[2];
  logic        prevSck[2], prevSdat[2];
  logic [15:0] capQ[$];

  // Slave-eye view: sample sdat on each sck rise, time sen/busy, log frames.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rises[i] <= 0; senLow[i] <= 0; busyCyc[i] <= 0; noTog[i] <= 0;
        cap[i] <= '0; prevSck[i] <= 1'b0; prevSdat[i] <= 1'b0;
      end else begin
        if (sck[i] && !prevSck[i]) begin
          rises[i] <= rises[i] + 1;
          cap[i] <= {cap[i][14:0], sdat[i]};
          if (sen[i]) senHighRise[i] <= senHighRise[i] + 1;
        end
        if (sck[i] && prevSck[i] && (sdat[i] !== prevSdat[i])) glitch[i] <= glitch[i] + 1;
        if (!sen[i]) senLow[i] <= senLow[i] + 1;
        if (busy[i]) busyCyc[i] <= busyCyc[i] + 1;
        if (!sen[i] && (sck[i] == prevSck[i])) noTog[i] <= noTog[i] + 1;
        if (done[i]) begin
          doneCnt[i]    <= doneCnt[i] + 1;
          lastCap[i]    <= cap[i];
          lastRises[i]  <= rises[i];
          lastSenLow[i] <= senLow[i];
          lastBusy[i]   <= busyCyc[i];
          lastNoTog[i]  <= noTog[i];
          rises[i] <= 0; senLow[i] <= 0; busyCyc[i] <= 0; noTog[i] <= 0;
          if (i == 0) capQ.push_back(cap[i]);
        end
        prevSck[i]  <= sck[i];
        prevSdat[i] <= sdat[i];
      end
    end
  end

  // reference: write flag 0, address in the upper byte, data below
  function automatic logic [15:0] expFrame(input int a, input int d);
    return 16'(a * 256 + d);
  endfunction

  function automatic logic [4:0] st(input int idx);
    return {sen[idx], sck[idx], sdat[idx], busy[idx], done[idx]};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic sendFrame(input int idx, input logic [6:0] a, input logic [7:0] d);
    if (idx == 0) begin
      busA.i_txBegin = 1'b1; busA.i_txAddress = a; busA.i_txData = d;
    end else begin
      busB.i_txBegin = 1'b1; busB.i_txAddress = a; busB.i_txData = d;
    end
    tick(1);
    busA.i_txBegin = 1'b0;
    busB.i_txBegin = 1'b0;
  endtask

  task automatic waitDone(input int idx, input int prev, input int budget, output bit ok);
    int n = 0;
    while (doneCnt[idx] == prev && n < budget) begin
      tick(1);
      n++;
    end
    ok = (doneCnt[idx] != prev);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      nVec++;
      if (st(i) !== 5'b10000) begin
        nMis++; $display("FAIL reset_hold[%0d]: got %b want 10000", i, st(i));
      end
    end
    rst_n = 1'b1;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      nVec++;
      if (st(i) !== 5'b10000) begin
        nMis++; $display("FAIL reset_idle[%0d]: got %b want 10000", i, st(i));
      end
    end
  endtask

  task automatic test_basic();
    int prev = doneCnt[0];
    bit ok;
    sendFrame(0, 7'h12, 8'h00);
    waitDone(0, prev, 400, ok);
    nVec++; if (!ok) begin nMis++; $display("FAIL basic_timeout: got no txDone want txDone"); end
    nVec++; if (lastCap[0] !== expFrame('h12, 0)) begin
      nMis++; $display("FAIL basic_cap: got %h want %h", lastCap[0], expFrame('h12, 0)); end
    nVec++; if (lastRises[0] != 16) begin
      nMis++; $display("FAIL basic_rises: got %0d want 16", lastRises[0]); end
    nVec++; if (lastSenLow[0] != 33 * hp[0]) begin
      nMis++; $display("FAIL basic_senlow: got %0d want %0d", lastSenLow[0], 33 * hp[0]); end
    nVec++; if (lastBusy[0] != 33 * hp[0]) begin
      nMis++; $display("FAIL basic_busy: got %0d want %0d", lastBusy[0], 33 * hp[0]); end
    tick(1);
    nVec++; if (done[0] !== 1'b0 || doneCnt[0] != prev + 1) begin
      nMis++; $display("FAIL basic_donepulse: got done=%b cnt=%0d want 0 cnt=%0d", done[0], doneCnt[0], prev + 1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 2; i++) begin
        logic [6:0] a = 7'($urandom_range(0, 127));
        logic [7:0] d = 8'($urandom_range(0, 255));
        int prev = doneCnt[i];
        bit ok;
        sendFrame(i, a, d);
        waitDone(i, prev, 400, ok);
        nVec++; if (!ok || lastCap[i] !== expFrame(a, d)) begin
          nMis++; $display("FAIL random_cap[%0d]: got %h ok=%0d want %h", i, lastCap[i], ok, expFrame(a, d)); end
        nVec++; if (lastBusy[i] != 33 * hp[i]) begin
          nMis++; $display("FAIL random_busy[%0d]: got %0d want %0d", i, lastBusy[i], 33 * hp[i]); end
        tick(1);
      end
    end
  endtask

  task automatic test_back_to_back();
    int prev = doneCnt[0];
    bit allOk = 1'b1;
    bit ok;
    capQ.delete();
    for (int k = 0; k <= 20; k++) begin
      sendFrame(0, 7'h12, 8'(k));
      waitDone(0, prev + k, 400, ok);
      allOk &= ok;
      tick(1);
    end
    tick(60);
    nVec++; if (!allOk || doneCnt[0] != prev + 21 || capQ.size() != 21) begin
      nMis++; $display("FAIL b2b_count: got %0d frames want 21", doneCnt[0] - prev); end
    for (int k = 0; k < capQ.size() && k <= 20; k++) begin
      nVec++; if (capQ[k] !== expFrame('h12, k)) begin
        nMis++; $display("FAIL b2b_frame[%0d]: got %h want %h", k, capQ[k], expFrame('h12, k)); end
    end
  endtask

  task automatic test_ignore_midframe();
    logic [6:0] a = 7'($urandom_range(0, 127));
    logic [7:0] d = 8'($urandom_range(0, 255));
    int prev = doneCnt[0];
    bit ok;
    sendFrame(0, a, d);
    tick(20);
    nVec++; if (busy[0] !== 1'b1) begin nMis++; $display("FAIL ignore_busy_pre: got %b want 1", busy[0]); end
    sendFrame(0, ~a, ~d);
    nVec++; if (busy[0] !== 1'b1) begin nMis++; $display("FAIL ignore_busy_post: got %b want 1", busy[0]); end
    waitDone(0, prev, 400, ok);
    nVec++; if (!ok || lastCap[0] !== expFrame(a, d)) begin
      nMis++; $display("FAIL ignore_cap: got %h want %h", lastCap[0], expFrame(a, d)); end
    nVec++; if (lastBusy[0] != 33 * hp[0]) begin
      nMis++; $display("FAIL ignore_busylen: got %0d want %0d", lastBusy[0], 33 * hp[0]); end
    tick(150);
    nVec++; if (doneCnt[0] != prev + 1 || busy[0] !== 1'b0) begin
      nMis++; $display("FAIL ignore_extra: got %0d frames busy=%b want 1 frame busy=0", doneCnt[0] - prev, busy[0]); end
  endtask

  task automatic test_pattern();
    int prev = doneCnt[0];
    bit ok;
    sendFrame(0, 7'h7F, 8'hA5);
    waitDone(0, prev, 400, ok);
    nVec++; if (!ok || lastCap[0] !== 16'h7FA5) begin
      nMis++; $display("FAIL pattern_cap: got %h want 7fa5", lastCap[0]); end
    nVec++; if (glitch[0] != 0 || glitch[1] != 0) begin
      nMis++; $display("FAIL pattern_sdat_stable: got %0d/%0d changes want 0", glitch[0], glitch[1]); end
    nVec++; if (senHighRise[0] != 0 || senHighRise[1] != 0) begin
      nMis++; $display("FAIL pattern_sen_rise: got %0d/%0d want 0", senHighRise[0], senHighRise[1]); end
    tick(1);
  endtask

  task automatic test_reset_abort();
    logic [6:0] a = 7'($urandom_range(0, 127));
    logic [7:0] d = 8'($urandom_range(0, 255));
    int prev = doneCnt[0];
    int n = 0;
    bit ok;
    sendFrame(0, a, d);
    while (rises[0] < 5 && n < 200) begin tick(1); n++; end
    nVec++; if (rises[0] < 5) begin nMis++; $display("FAIL abort_reach: got %0d rises want 5", rises[0]); end
    #2;
    rst_n = 1'b0;
    busA.i_txBegin = 1'b1;
    #1;
    nVec++; if ({sen[0], sck[0], busy[0]} !== 3'b100) begin
      nMis++; $display("FAIL abort_async: got sen/sck/busy=%b want 100", {sen[0], sck[0], busy[0]}); end
    tick(3);
    rst_n = 1'b1;
    busA.i_txBegin = 1'b0;
    tick(5);
    nVec++; if (doneCnt[0] != prev || busy[0] !== 1'b0) begin
      nMis++; $display("FAIL abort_nodone: got %0d dones busy=%b want 0 busy=0", doneCnt[0] - prev, busy[0]); end
    sendFrame(0, ~a, d + 8'd1);
    waitDone(0, prev, 400, ok);
    nVec++; if (!ok || lastCap[0] !== expFrame(~a & 7'h7F, (d + 1) & 8'hFF) || lastRises[0] != 16) begin
      nMis++; $display("FAIL abort_next: got %h rises=%0d want %h", lastCap[0], lastRises[0], expFrame(~a & 7'h7F, (d + 1) & 8'hFF)); end
    tick(1);
  endtask

  task automatic test_hp1();
    logic [6:0] a = 7'($urandom_range(0, 127));
    int prev = doneCnt[1];
    bit ok;
    sendFrame(1, a, 8'h3C);
    waitDone(1, prev, 200, ok);
    nVec++; if (!ok || lastCap[1] !== expFrame(a, 'h3C)) begin
      nMis++; $display("FAIL hp1_cap: got %h want %h", lastCap[1], expFrame(a, 'h3C)); end
    nVec++; if (lastBusy[1] != 33 || lastSenLow[1] != 33) begin
      nMis++; $display("FAIL hp1_len: got busy=%0d sen=%0d want 33", lastBusy[1], lastSenLow[1]); end
    nVec++; if (lastNoTog[1] != 1 || lastRises[1] != 16) begin
      nMis++; $display("FAIL hp1_toggle: got steady=%0d rises=%0d want 1 and 16", lastNoTog[1], lastRises[1]); end
    tick(1);
  endtask

  initial begin
    busA.i_txBegin = 1'b0; busA.i_txAddress = '0; busA.i_txData = '0;
    busB.i_txBegin = 1'b0; busB.i_txAddress = '0; busB.i_txData = '0;
    test_reset();
    test_basic();
    test_random();
    test_back_to_back();
    test_ignore_midframe();
    test_pattern();
    test_reset_abort();
    test_hp1();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of run want finish before 1000000");
    $fatal(1, "watchdog");
  end
endmodule
